// File: rtl/trap_ctrl_if.sv
// Trap controller bus: EX-stage event inputs and redirect/CSR outputs.
// slave = trap_ctrl side, master = pipeline/next-PC side.
interface trap_ctrl_if;
    logic        ext_int_req;
    logic        ex_valid;
    logic        stall;
    logic [31:0] pc_ex;
    logic        ill_ex;
    logic        ecall_ex;
    logic        mret_ex;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] sepc;
    logic [31:0] scause;
    logic        in_handler;
    logic [31:0] trap_count;

    modport slave (
        input  ext_int_req, ex_valid, stall, pc_ex,
        input  ill_ex, ecall_ex, mret_ex,
        output redirect, redirect_pc, flush,
        output sepc, scause, in_handler, trap_count
    );

    modport master (
        output ext_int_req, ex_valid, stall, pc_ex,
        output ill_ex, ecall_ex, mret_ex,
        input  redirect, redirect_pc, flush,
        input  sepc, scause, in_handler, trap_count
    );
endinterface

// File: rtl/trap_ctrl.sv
// Trap entry/return sequencer: arbitrates ILL/ECALL/external IRQ in EX,
// keeps SEPC/SCAUSE, and issues a one-cycle redirect+flush to next-PC.
// Ports: clk, rstn (sync, active-low), bus (trap_ctrl_if.slave).
// Optional: define TRAP_CNT_EN to enable the trap_count register.
module trap_ctrl #(
    parameter logic [31:0] VEC_EXT   = 32'h00000a7c,
    parameter logic [31:0] VEC_ILL   = 32'h00000b78,
    parameter logic [31:0] VEC_ECALL = 32'h00000b28
) (
    input  logic         clk,
    input  logic         rstn,
    trap_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENTER   = 2'd1,
        HANDLER = 2'd2,
        RETURN  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        int_pend_q, int_pend_d;
    logic        ext_prev_q;
    logic [31:0] sepc_q, sepc_d;
    logic [31:0] scause_q, scause_d;
    logic [31:0] rpc_q, rpc_d;
    logic        take_trap;
    logic        take_int;
    logic        eligible;
    logic        ext_rise;

    assign eligible = bus.ex_valid & ~bus.stall;
    assign ext_rise = bus.ext_int_req & ~ext_prev_q;

    always_comb begin
        state_d   = state_q;
        sepc_d    = sepc_q;
        scause_d  = scause_q;
        rpc_d     = rpc_q;
        take_trap = 1'b0;
        take_int  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (eligible) begin
                    if (bus.ill_ex) begin
                        take_trap = 1'b1;
                        scause_d  = 32'd2;
                        sepc_d    = bus.pc_ex + 32'd4;
                        rpc_d     = VEC_ILL;
                    end else if (bus.ecall_ex) begin
                        take_trap = 1'b1;
                        scause_d  = 32'd8;
                        sepc_d    = bus.pc_ex + 32'd4;
                        rpc_d     = VEC_ECALL;
                    end else if (int_pend_q) begin
                        // EX instruction is killed and replayed on return
                        take_trap = 1'b1;
                        take_int  = 1'b1;
                        scause_d  = 32'd1;
                        sepc_d    = bus.pc_ex;
                        rpc_d     = VEC_EXT;
                    end
                    if (take_trap) state_d = ENTER;
                end
            end
            ENTER: state_d = HANDLER;
            HANDLER: begin
                if (eligible && bus.mret_ex) begin
                    rpc_d   = sepc_q;
                    state_d = RETURN;
                end
            end
            RETURN: state_d = IDLE;
        endcase
        // a fresh edge in the same cycle as the take re-arms the request
        int_pend_d = ext_rise | (int_pend_q & ~take_int);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            int_pend_q <= 1'b0;
            // track the level during reset so a held request is not an edge
            ext_prev_q <= bus.ext_int_req;
            sepc_q     <= '0;
            scause_q   <= '0;
            rpc_q      <= '0;
        end else begin
            state_q    <= state_d;
            int_pend_q <= int_pend_d;
            ext_prev_q <= bus.ext_int_req;
            sepc_q     <= sepc_d;
            scause_q   <= scause_d;
            rpc_q      <= rpc_d;
        end
    end

`ifdef TRAP_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rstn) cnt_q <= '0;
        else if (take_trap) cnt_q <= cnt_q + 32'd1;
    end

    assign bus.trap_count = cnt_q;
`else
    assign bus.trap_count = '0;
`endif

    assign bus.redirect    = (state_q == ENTER) || (state_q == RETURN);
    assign bus.flush       = (state_q == ENTER) || (state_q == RETURN);
    assign bus.in_handler  = (state_q != IDLE);
    assign bus.redirect_pc = rpc_q;
    assign bus.sepc        = sepc_q;
    assign bus.scause      = scause_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: reset, ECALL, priority, stall,
// MRET, nesting block, wrap, mid-handler reset, trap counter.
module tb_trap_ctrl;

    logic clk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   failures = 0;

    trap_ctrl_if bus ();

    trap_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

`ifdef TRAP_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.ex_valid = 1'b0;
        bus.stall    = 1'b0;
        bus.ill_ex   = 1'b0;
        bus.ecall_ex = 1'b0;
        bus.mret_ex  = 1'b0;
    endtask

    task automatic chk_pulse(input string tag, input logic [31:0] rpc);
        chk({tag, "_redir"}, {31'd0, bus.redirect}, 32'd1);
        chk({tag, "_flush"}, {31'd0, bus.flush}, 32'd1);
        chk({tag, "_rpc"}, bus.redirect_pc, rpc);
        chk({tag, "_inh"}, {31'd0, bus.in_handler}, 32'd1);
    endtask

    // HANDLER -> issue MRET -> RETURN -> IDLE
    task automatic do_mret(input string tag, input logic [31:0] rpc);
        idle_in();
        step();
        chk({tag, "_hnd_redir"}, {31'd0, bus.redirect}, 32'd0);
        bus.ex_valid = 1'b1;
        bus.mret_ex  = 1'b1;
        bus.pc_ex    = 32'h0000_0c00;
        step();
        chk_pulse({tag, "_ret"}, rpc);
        idle_in();
        step();
        chk({tag, "_idle_inh"}, {31'd0, bus.in_handler}, 32'd0);
        chk({tag, "_idle_redir"}, {31'd0, bus.redirect}, 32'd0);
    endtask

    initial begin
        idle_in();
        bus.pc_ex       = '0;
        bus.ext_int_req = 1'b1;
        rstn            = 1'b0;
        step();
        step();
        chk("rst_redir", {31'd0, bus.redirect}, 32'd0);
        chk("rst_flush", {31'd0, bus.flush}, 32'd0);
        chk("rst_inh", {31'd0, bus.in_handler}, 32'd0);
        chk("rst_rpc", bus.redirect_pc, 32'd0);
        chk("rst_sepc", bus.sepc, 32'd0);
        chk("rst_scause", bus.scause, 32'd0);
        chk("rst_cnt", bus.trap_count, 32'd0);

        // held-high request across reset release must not pend
        rstn         = 1'b1;
        bus.ex_valid = 1'b1;
        bus.pc_ex    = 32'h0000_0050;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("nopend_redir", {31'd0, bus.redirect}, 32'd0);
        end
        bus.ext_int_req = 1'b0;

        // ECALL
        bus.pc_ex    = 32'h0000_0100;
        bus.ecall_ex = 1'b1;
        step();
        chk_pulse("ecall", 32'h0000_0b28);
        chk("ecall_sepc", bus.sepc, 32'h0000_0104);
        chk("ecall_scause", bus.scause, 32'd8);
        idle_in();
        step();
        chk("hnd_redir", {31'd0, bus.redirect}, 32'd0);
        chk("hnd_inh", {31'd0, bus.in_handler}, 32'd1);
        // no nesting
        bus.ex_valid = 1'b1;
        bus.ill_ex   = 1'b1;
        bus.pc_ex    = 32'h0000_0b28;
        step();
        chk("nest_redir", {31'd0, bus.redirect}, 32'd0);
        chk("nest_scause", bus.scause, 32'd8);
        do_mret("m1", 32'h0000_0104);
        // MRET in IDLE is a NOP
        bus.ex_valid = 1'b1;
        bus.mret_ex  = 1'b1;
        step();
        chk("mret_idle_redir", {31'd0, bus.redirect}, 32'd0);
        idle_in();

        // ILL beats pending interrupt, IRQ taken after return
        bus.ext_int_req = 1'b1;
        step();
        bus.ext_int_req = 1'b0;
        bus.ex_valid    = 1'b1;
        bus.ill_ex      = 1'b1;
        bus.pc_ex       = 32'h0000_0200;
        step();
        chk_pulse("ill", 32'h0000_0b78);
        chk("ill_scause", bus.scause, 32'd2);
        chk("ill_sepc", bus.sepc, 32'h0000_0204);
        do_mret("m2", 32'h0000_0204);
        bus.ex_valid = 1'b1;
        bus.pc_ex    = 32'h0000_0204;
        step();
        chk_pulse("irq", 32'h0000_0a7c);
        chk("irq_scause", bus.scause, 32'd1);
        chk("irq_sepc", bus.sepc, 32'h0000_0204);
        do_mret("m3", 32'h0000_0204);
        chk("cnt3", bus.trap_count, CNT_ON ? 32'd3 : 32'd0);

        // stall blocks the pending interrupt
        bus.ext_int_req = 1'b1;
        step();
        bus.ext_int_req = 1'b0;
        bus.ex_valid    = 1'b1;
        bus.stall       = 1'b1;
        bus.pc_ex       = 32'h0000_0300;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_redir", {31'd0, bus.redirect}, 32'd0);
        end
        bus.stall = 1'b0;
        step();
        chk_pulse("stall_irq", 32'h0000_0a7c);
        chk("stall_sepc", bus.sepc, 32'h0000_0300);
        do_mret("m4", 32'h0000_0300);

        // pc+4 wraps
        bus.ex_valid = 1'b1;
        bus.ecall_ex = 1'b1;
        bus.pc_ex    = 32'hffff_fffc;
        step();
        chk("wrap_sepc", bus.sepc, 32'd0);
        do_mret("m5", 32'd0);
        chk("cnt5", bus.trap_count, CNT_ON ? 32'd5 : 32'd0);

        // reset inside the handler aborts with no redirect
        bus.ex_valid = 1'b1;
        bus.ill_ex   = 1'b1;
        bus.pc_ex    = 32'h0000_0400;
        step();
        idle_in();
        step();
        rstn = 1'b0;
        step();
        chk("mrst_redir", {31'd0, bus.redirect}, 32'd0);
        chk("mrst_inh", {31'd0, bus.in_handler}, 32'd0);
        chk("mrst_sepc", bus.sepc, 32'd0);
        chk("mrst_cnt", bus.trap_count, 32'd0);
        rstn = 1'b1;
        step();
        chk("post_rst_redir", {31'd0, bus.redirect}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
